// File: rtl/eth_rx_dispatch.sv
// Ethernet receive dispatcher: parses the 14-byte header, filters on destination
// MAC, steers accepted payloads to a channel picked from a runtime ethertype
// table, and keeps saturating frame statistics.
module eth_rx_dispatch #(
  parameter int unsigned N_CHAN = 4,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned CW    = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic             rx_clk,
  input  logic             reset_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             in_eof,
  input  logic             in_err,
  input  logic [47:0]      local_mac,
  input  logic             promisc,
  input  logic             accept_mcast,
  input  logic             cfg_we,
  input  logic [CW-1:0]    cfg_idx,
  input  logic [15:0]      cfg_ethertype,
  input  logic             cfg_en,
  input  logic             stat_clr,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic             out_err,
  output logic             out_abort,
  output logic [CW-1:0]    out_chan,
  output logic [CNT_W-1:0] cnt_fwd,
  output logic [CNT_W-1:0] cnt_drop_mac,
  output logic [CNT_W-1:0] cnt_drop_type,
  output logic [CNT_W-1:0] cnt_runt
);

  localparam int unsigned HC_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_FWD, S_DROP} state_e;

  state_e            state_q, state_d;
  logic [HC_W-1:0]   hdr_cnt_q, hdr_cnt_d;
  logic [47:0]       dst_q, dst_d;
  logic [7:0]        et_hi_q, et_hi_d;
  logic              first_q, first_d;
  logic [CW-1:0]     chan_q, chan_d;
  logic [15:0]       tbl_type_q [N_CHAN];
  logic [15:0]       tbl_type_d [N_CHAN];
  logic [N_CHAN-1:0] tbl_en_q, tbl_en_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_sof_q, out_sof_d;
  logic              out_eof_q, out_eof_d;
  logic              out_err_q, out_err_d;
  logic              out_abort_q, out_abort_d;
  logic [CNT_W-1:0]  cnt_fwd_q, cnt_fwd_d;
  logic [CNT_W-1:0]  cnt_mac_q, cnt_mac_d;
  logic [CNT_W-1:0]  cnt_type_q, cnt_type_d;
  logic [CNT_W-1:0]  cnt_runt_q, cnt_runt_d;
  logic              inc_fwd, inc_mac, inc_type, inc_runt;
  logic [15:0]       et_c;
  logic              hit_c, mac_ok_c;
  logic [CW-1:0]     hit_idx_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Table write path; a write lands at the clock edge and is seen by the next decision.
  always_comb begin
    tbl_type_d = tbl_type_q;
    tbl_en_d   = tbl_en_q;
    if (cfg_we && (32'(cfg_idx) < N_CHAN)) begin
      tbl_type_d[cfg_idx] = cfg_ethertype;
      tbl_en_d[cfg_idx]   = cfg_en;
    end
  end

  // Byte-13 decision inputs: MAC filter and lowest-index enabled ethertype match.
  always_comb begin
    et_c      = {et_hi_q, in_data};
    hit_c     = 1'b0;
    hit_idx_c = '0;
    for (int i = N_CHAN - 1; i >= 0; i--) begin
      if (tbl_en_q[i] && (tbl_type_q[i] == et_c)) begin
        hit_c     = 1'b1;
        hit_idx_c = CW'(i);
      end
    end
    mac_ok_c = promisc | (dst_q == local_mac) | (&dst_q) | (accept_mcast & dst_q[40]);
  end

  // Frame FSM: header parse, forward/drop, and registered output pulses.
  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    dst_d       = dst_q;
    et_hi_d     = et_hi_q;
    first_d     = first_q;
    chan_d      = chan_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_sof_d   = 1'b0;
    out_eof_d   = 1'b0;
    out_err_d   = 1'b0;
    out_abort_d = 1'b0;
    inc_fwd     = 1'b0;
    inc_mac     = 1'b0;
    inc_type    = 1'b0;
    inc_runt    = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        // A new frame always restarts the parser; abandon whatever was in flight.
        if (state_q == S_FWD) out_abort_d = 1'b1;
        if (state_q == S_HDR) inc_runt = 1'b1;
        dst_d     = {40'h0, in_data};
        hdr_cnt_d = HC_W'(1);
        if (in_eof) begin
          state_d = S_IDLE;
          if (state_q != S_HDR) inc_runt = 1'b1;
        end else begin
          state_d = S_HDR;
        end
      end else begin
        case (state_q)
          S_HDR: begin
            hdr_cnt_d = hdr_cnt_q + HC_W'(1);
            if (hdr_cnt_q < HC_W'(6)) dst_d = {dst_q[39:0], in_data};
            if (hdr_cnt_q == HC_W'(12)) et_hi_d = in_data;
            if (in_eof) begin
              state_d  = S_IDLE;
              inc_runt = 1'b1;
            end else if (hdr_cnt_q == HC_W'(13)) begin
              if (!mac_ok_c) begin
                state_d = S_DROP;
                inc_mac = 1'b1;
              end else if (hit_c) begin
                state_d = S_FWD;
                chan_d  = hit_idx_c;
                first_d = 1'b1;
              end else begin
                state_d  = S_DROP;
                inc_type = 1'b1;
              end
            end
          end
          S_FWD: begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_sof_d   = first_q;
            out_eof_d   = in_eof;
            out_err_d   = in_eof & in_err;
            first_d     = 1'b0;
            if (in_eof) begin
              state_d = S_IDLE;
              inc_fwd = 1'b1;
            end
          end
          S_DROP: begin
            if (in_eof) state_d = S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Saturating statistics; clear takes priority over a coincident increment.
  always_comb begin
    cnt_fwd_d  = inc_fwd  ? sat_inc(cnt_fwd_q)  : cnt_fwd_q;
    cnt_mac_d  = inc_mac  ? sat_inc(cnt_mac_q)  : cnt_mac_q;
    cnt_type_d = inc_type ? sat_inc(cnt_type_q) : cnt_type_q;
    cnt_runt_d = inc_runt ? sat_inc(cnt_runt_q) : cnt_runt_q;
    if (stat_clr) begin
      cnt_fwd_d  = '0;
      cnt_mac_d  = '0;
      cnt_type_d = '0;
      cnt_runt_d = '0;
    end
  end

  // State, table, output and counter registers.
  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      hdr_cnt_q   <= '0;
      dst_q       <= '0;
      et_hi_q     <= '0;
      first_q     <= 1'b0;
      chan_q      <= '0;
      tbl_type_q  <= '{default: '0};
      tbl_en_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_abort_q <= 1'b0;
      cnt_fwd_q   <= '0;
      cnt_mac_q   <= '0;
      cnt_type_q  <= '0;
      cnt_runt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      dst_q       <= dst_d;
      et_hi_q     <= et_hi_d;
      first_q     <= first_d;
      chan_q      <= chan_d;
      tbl_type_q  <= tbl_type_d;
      tbl_en_q    <= tbl_en_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      out_err_q   <= out_err_d;
      out_abort_q <= out_abort_d;
      cnt_fwd_q   <= cnt_fwd_d;
      cnt_mac_q   <= cnt_mac_d;
      cnt_type_q  <= cnt_type_d;
      cnt_runt_q  <= cnt_runt_d;
    end
  end

  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_sof       = out_sof_q;
  assign out_eof       = out_eof_q;
  assign out_err       = out_err_q;
  assign out_abort     = out_abort_q;
  assign out_chan      = chan_q;
  assign cnt_fwd       = cnt_fwd_q;
  assign cnt_drop_mac  = cnt_mac_q;
  assign cnt_drop_type = cnt_type_q;
  assign cnt_runt      = cnt_runt_q;

endmodule

// File: tb/tb_eth_rx_dispatch.sv
// Bench for eth_rx_dispatch: frame-level reference model plus per-scenario tasks.
module tb_eth_rx_dispatch;

  localparam int unsigned N_CHAN = 4;
  localparam int unsigned CW     = 2;
  localparam int K_FWD = 0, K_DMAC = 1, K_DTYPE = 2, K_RUNT = 3;
  localparam logic [47:0] LMAC  = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OMAC  = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;

  typedef byte unsigned byte_q_t[$];

  logic rx_clk = 1'b0;
  logic reset_n;
  logic [7:0] in_data;
  logic in_valid, in_sof, in_eof, in_err;
  logic [47:0] local_mac;
  logic promisc, accept_mcast, cfg_we, cfg_en, stat_clr;
  logic [CW-1:0] cfg_idx;
  logic [15:0] cfg_ethertype;

  logic [7:0] out_data;
  logic out_valid, out_sof, out_eof, out_err, out_abort;
  logic [CW-1:0] out_chan;
  logic [15:0] cnt_fwd, cnt_drop_mac, cnt_drop_type, cnt_runt;

  logic [7:0] s_out_data;
  logic s_out_valid, s_out_sof, s_out_eof, s_out_err, s_out_abort;
  logic [CW-1:0] s_out_chan;
  logic [3:0] s_cnt_fwd, s_cnt_drop_mac, s_cnt_drop_type, s_cnt_runt;

  eth_rx_dispatch #(.N_CHAN(N_CHAN), .CNT_W(16)) dut (
    .rx_clk(rx_clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_sof(in_sof), .in_eof(in_eof), .in_err(in_err), .local_mac(local_mac),
    .promisc(promisc), .accept_mcast(accept_mcast), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_ethertype(cfg_ethertype), .cfg_en(cfg_en), .stat_clr(stat_clr),
    .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .out_err(out_err), .out_abort(out_abort), .out_chan(out_chan), .cnt_fwd(cnt_fwd),
    .cnt_drop_mac(cnt_drop_mac), .cnt_drop_type(cnt_drop_type), .cnt_runt(cnt_runt));

  // Narrow-counter instance so saturation is reachable in a short run.
  eth_rx_dispatch #(.N_CHAN(N_CHAN), .CNT_W(4)) dut_s (
    .rx_clk(rx_clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_sof(in_sof), .in_eof(in_eof), .in_err(in_err), .local_mac(local_mac),
    .promisc(promisc), .accept_mcast(accept_mcast), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_ethertype(cfg_ethertype), .cfg_en(cfg_en), .stat_clr(stat_clr),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_sof(s_out_sof), .out_eof(s_out_eof),
    .out_err(s_out_err), .out_abort(s_out_abort), .out_chan(s_out_chan), .cnt_fwd(s_cnt_fwd),
    .cnt_drop_mac(s_cnt_drop_mac), .cnt_drop_type(s_cnt_drop_type), .cnt_runt(s_cnt_runt));

  always #5 rx_clk = ~rx_clk;

  int tests = 0, fails = 0;

  // Reference model state
  logic [15:0] m_type[N_CHAN];
  bit m_en[N_CHAN];
  int n_fwd, n_mac, n_type, n_runt;
  bit exp_abort;

  // Output monitor state
  byte_q_t got, s_got;
  int sof_cnt, eof_cnt, err_cnt, abort_cnt, stray, chan_first, chan_bad;
  int s_ev, s_chan_bad;

  always @(negedge rx_clk) begin
    if (out_valid) begin
      if (got.size() == 0) chan_first = int'(out_chan);
      else if (int'(out_chan) != chan_first) chan_bad++;
      if (out_sof) begin
        sof_cnt++;
        if (got.size() != 0) stray++;
      end
      if (out_eof) eof_cnt++;
      if (out_err) err_cnt++;
      got.push_back(out_data);
    end else if (out_sof || out_eof || out_err) begin
      stray++;
    end
    if (out_abort) begin
      abort_cnt++;
      if (out_valid) stray++;
    end
    if (s_out_valid) s_got.push_back(s_out_data);
    s_ev += int'(s_out_sof) + int'(s_out_eof) + int'(s_out_err) + int'(s_out_abort);
    if (s_out_valid && s_out_sof && int'(s_out_chan) != chan_first) s_chan_bad++;
  end

  task automatic mon_clear();
    got.delete(); s_got.delete();
    sof_cnt = 0; eof_cnt = 0; err_cnt = 0; abort_cnt = 0; stray = 0;
    chan_first = -1; chan_bad = 0; s_ev = 0; s_chan_bad = 0;
  endtask

  function automatic int satv(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic byte_q_t mk(input logic [47:0] dst, input logic [15:0] et, input int len);
    byte_q_t f;
    for (int i = 0; i < len; i++) begin
      if (i < 6) f.push_back(dst[47 - 8*i -: 8]);
      else if (i == 12) f.push_back(et[15:8]);
      else if (i == 13) f.push_back(et[7:0]);
      else f.push_back(8'($urandom));
    end
    return f;
  endfunction

  // Frame-level classification straight from the header rules.
  function automatic int classify(input byte_q_t f, output int ch);
    logic [47:0] dst;
    logic [15:0] et;
    ch = 0;
    if (f.size() < 15) return K_RUNT;
    dst = {f[0], f[1], f[2], f[3], f[4], f[5]};
    et  = {f[12], f[13]};
    if (!(promisc || dst == local_mac || dst == BCAST || (accept_mcast && dst[40]))) return K_DMAC;
    for (int i = 0; i < N_CHAN; i++)
      if (m_en[i] && m_type[i] == et) begin
        ch = i;
        return K_FWD;
      end
    return K_DTYPE;
  endfunction

  task automatic drive(input logic [7:0] d, input logic v, input logic s, input logic e, input logic er);
    @(negedge rx_clk);
    cfg_we = 1'b0; stat_clr = 1'b0;
    in_data = d; in_valid = v; in_sof = s; in_eof = e; in_err = er;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cfg_write(input int idx, input logic [15:0] et, input bit en);
    idle(1);
    cfg_we = 1'b1; cfg_idx = CW'(idx); cfg_ethertype = et; cfg_en = en;
    m_type[idx] = et; m_en[idx] = en;
    idle(1);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CHAN; i++) begin m_type[i] = 16'h0; m_en[i] = 0; end
    n_fwd = 0; n_mac = 0; n_type = 0; n_runt = 0; exp_abort = 0;
  endtask

  // Send one frame and score every observable against the model.
  task automatic send_frame(input byte_q_t f, input bit err, input bit gaps, input bit no_eof,
                            input int wr_at, input int wr_idx, input logic [15:0] wr_type,
                            input bit wr_en, input bit clr_eof);
    int kind, ch, mism, e_sof, e_eof, e_err;
    bit ab;
    byte_q_t exp;
    kind = classify(f, ch);
    ab = exp_abort; exp_abort = 0;
    mon_clear();
    for (int i = 0; i < f.size(); i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      drive(f[i], 1'b1, i == 0, (i == f.size() - 1) && !no_eof, err && (i == f.size() - 1));
      if (i == wr_at) begin
        cfg_we = 1'b1; cfg_idx = CW'(wr_idx); cfg_ethertype = wr_type; cfg_en = wr_en;
        m_type[wr_idx] = wr_type; m_en[wr_idx] = wr_en;
      end
      if (clr_eof && i == f.size() - 1) stat_clr = 1'b1;
    end
    idle(2);
    if (no_eof) begin
      if (kind == K_FWD) exp_abort = 1;
    end else begin
      case (kind)
        K_FWD:   n_fwd++;
        K_DMAC:  n_mac++;
        K_DTYPE: n_type++;
        default: n_runt++;
      endcase
    end
    if (clr_eof) begin n_fwd = 0; n_mac = 0; n_type = 0; n_runt = 0; end
    if (kind == K_FWD) for (int i = 14; i < f.size(); i++) exp.push_back(f[i]);
    e_sof = (kind == K_FWD) ? 1 : 0;
    e_eof = (kind == K_FWD && !no_eof) ? 1 : 0;
    e_err = (e_eof == 1 && err) ? 1 : 0;

    mism = (got.size() != exp.size()) ? 1 : 0;
    if (mism == 0) for (int i = 0; i < exp.size(); i++) if (got[i] != exp[i]) mism++;
    tests++;
    if (mism != 0) begin
      fails++;
      $display("FAIL payload: got %0d bytes (%0d diffs), want %0d bytes", got.size(), mism, exp.size());
    end
    tests++;
    if (sof_cnt !== e_sof || eof_cnt !== e_eof || err_cnt !== e_err || abort_cnt !== int'(ab) || stray !== 0) begin
      fails++;
      $display("FAIL flags: sof=%0d eof=%0d err=%0d abort=%0d stray=%0d, want sof=%0d eof=%0d err=%0d abort=%0d stray=0",
               sof_cnt, eof_cnt, err_cnt, abort_cnt, stray, e_sof, e_eof, e_err, ab);
    end
    if (kind == K_FWD) begin
      tests++;
      if (chan_first !== ch || chan_bad !== 0) begin
        fails++;
        $display("FAIL chan: got %0d (changes %0d), want %0d", chan_first, chan_bad, ch);
      end
    end
    tests++;
    if ({cnt_fwd, cnt_drop_mac, cnt_drop_type, cnt_runt} !==
        {16'(satv(n_fwd, 16)), 16'(satv(n_mac, 16)), 16'(satv(n_type, 16)), 16'(satv(n_runt, 16))}) begin
      fails++;
      $display("FAIL counters: got fwd=%0d mac=%0d type=%0d runt=%0d, want %0d %0d %0d %0d",
               cnt_fwd, cnt_drop_mac, cnt_drop_type, cnt_runt, n_fwd, n_mac, n_type, n_runt);
    end
    tests++;
    if ({s_cnt_fwd, s_cnt_drop_mac, s_cnt_drop_type, s_cnt_runt} !==
        {4'(satv(n_fwd, 4)), 4'(satv(n_mac, 4)), 4'(satv(n_type, 4)), 4'(satv(n_runt, 4))}) begin
      fails++;
      $display("FAIL sat_counters: got fwd=%0d mac=%0d type=%0d runt=%0d, want %0d %0d %0d %0d",
               s_cnt_fwd, s_cnt_drop_mac, s_cnt_drop_type, s_cnt_runt,
               satv(n_fwd, 4), satv(n_mac, 4), satv(n_type, 4), satv(n_runt, 4));
    end
    tests++;
    if (s_got.size() != exp.size() || s_ev !== e_sof + e_eof + e_err + int'(ab) || s_chan_bad !== 0) begin
      fails++;
      $display("FAIL narrow_out: got %0d bytes %0d events, want %0d bytes %0d events",
               s_got.size(), s_ev, exp.size(), e_sof + e_eof + e_err + int'(ab));
    end
  endtask

  task automatic send(input byte_q_t f, input bit err);
    send_frame(f, err, 1'b0, 1'b0, -1, 0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge rx_clk);
    tests++;
    if ({out_data, out_valid, out_sof, out_eof, out_err, out_abort, out_chan} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, want 0", {out_data, out_valid, out_sof, out_eof, out_err, out_abort, out_chan});
    end
    tests++;
    if ({cnt_fwd, cnt_drop_mac, cnt_drop_type, cnt_runt} !== '0) begin
      fails++;
      $display("FAIL reset_counters: got %h, want 0", {cnt_fwd, cnt_drop_mac, cnt_drop_type, cnt_runt});
    end
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    cfg_write(1, 16'h0800, 1);
    send(mk(LMAC, 16'h0800, 64), 1'b0);
    // Entries are disabled after reset, so a type-0 frame must not hit entry 0.
    send(mk(LMAC, 16'h0000, 30), 1'b0);
  endtask

  task automatic test_filter();
    send(mk(BCAST, 16'h86DD, 60), 1'b0);
    send(mk(OMAC, 16'h0800, 60), 1'b0);
    promisc = 1'b1; idle(1);
    send(mk(OMAC, 16'h0800, 60), 1'b0);
    promisc = 1'b0; idle(1);
    send(mk(MCAST, 16'h0800, 40), 1'b0);
    accept_mcast = 1'b1; idle(1);
    send(mk(MCAST, 16'h0800, 40), 1'b0);
    accept_mcast = 1'b0; idle(1);
  endtask

  task automatic test_priority();
    cfg_write(0, 16'h0806, 1);
    cfg_write(2, 16'h0806, 1);
    // Disable entry 0 while byte 20 is on the wire: this frame keeps channel 0.
    send_frame(mk(LMAC, 16'h0806, 40), 1'b0, 1'b0, 1'b0, 20, 0, 16'h0806, 1'b0, 1'b0);
    send(mk(LMAC, 16'h0806, 40), 1'b0);
  endtask

  task automatic test_runt();
    send(mk(LMAC, 16'h0800, 10), 1'b0);
    send(mk(LMAC, 16'h0800, 14), 1'b0);
    send(mk(LMAC, 16'h0800, 1), 1'b0);
    mon_clear();
    for (int i = 0; i < 20; i++) drive(8'(i), 1'b1, 1'b0, i == 19, 1'b0);
    idle(2);
    tests++;
    if (got.size() != 0 || {cnt_fwd, cnt_drop_mac, cnt_drop_type, cnt_runt} !==
        {16'(n_fwd), 16'(n_mac), 16'(n_type), 16'(n_runt)}) begin
      fails++;
      $display("FAIL idle_ignore: got %0d bytes runt=%0d, want 0 bytes runt=%0d", got.size(), cnt_runt, n_runt);
    end
  endtask

  task automatic test_abort();
    send_frame(mk(LMAC, 16'h0800, 34), 1'b0, 1'b0, 1'b1, -1, 0, 16'h0, 1'b0, 1'b0);
    send(mk(LMAC, 16'h0800, 30), 1'b0);
  endtask

  task automatic test_err();
    send(mk(LMAC, 16'h0800, 48), 1'b1);
    send_frame(mk(BCAST, 16'h0806, 33), 1'b1, 1'b1, 1'b0, -1, 0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 17; k++) send(mk(LMAC, 16'h0800, 15), 1'b0);
    send_frame(mk(LMAC, 16'h0800, 20), 1'b0, 1'b0, 1'b0, -1, 0, 16'h0, 1'b0, 1'b1);
    send(mk(OMAC, 16'h0800, 20), 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] types[4];
    logic [47:0] dst;
    types[0] = 16'h0800; types[1] = 16'h0806; types[2] = 16'h86DD; types[3] = 16'h88B5;
    for (int i = 0; i < N_CHAN; i++) cfg_write(i, types[$urandom_range(0, 3)], 1'($urandom));
    for (int k = 0; k < 30; k++) begin
      promisc = ($urandom_range(0, 4) == 0);
      accept_mcast = 1'($urandom);
      case ($urandom_range(0, 3))
        0: dst = LMAC;
        1: dst = BCAST;
        2: dst = MCAST;
        default: dst = {$urandom, $urandom} & ~(48'h1 << 40);
      endcase
      send_frame(mk(dst, types[$urandom_range(0, 3)], $urandom_range(5, 40)), 1'($urandom), 1'b1,
                 1'b0, -1, 0, 16'h0, 1'b0, 1'b0);
    end
    promisc = 1'b0; accept_mcast = 1'b0;
  endtask

  task automatic test_reset_mid();
    byte_q_t f;
    int pre_valid, n_at_rst;
    cfg_write(1, 16'h0800, 1);
    f = mk(LMAC, 16'h0800, 40);
    mon_clear();
    for (int i = 0; i < 25; i++) drive(f[i], 1'b1, i == 0, 1'b0, 1'b0);
    @(posedge rx_clk); #1;
    pre_valid = int'(out_valid);
    reset_n = 1'b0;
    #1;
    tests++;
    if (pre_valid != 1 || {out_data, out_valid, out_sof, out_eof, out_err, out_abort, out_chan} !== '0 ||
        {cnt_fwd, cnt_drop_mac, cnt_drop_type, cnt_runt} !== '0) begin
      fails++;
      $display("FAIL reset_mid: pre_valid=%0d out=%h cnt=%h, want pre_valid=1 out=0 cnt=0", pre_valid,
               {out_data, out_valid, out_sof, out_eof, out_err, out_abort, out_chan},
               {cnt_fwd, cnt_drop_mac, cnt_drop_type, cnt_runt});
    end
    @(negedge rx_clk);
    reset_n = 1'b1;
    model_reset();
    n_at_rst = got.size();
    for (int i = 25; i < 40; i++) drive(f[i], 1'b1, 1'b0, i == 39, 1'b0);
    idle(2);
    tests++;
    if (got.size() != n_at_rst || eof_cnt != 0 || cnt_fwd !== 16'h0) begin
      fails++;
      $display("FAIL reset_mid_tail: got %0d extra bytes eof=%0d fwd=%0d, want 0 0 0",
               got.size() - n_at_rst, eof_cnt, cnt_fwd);
    end
  endtask

  initial begin
    in_data = '0; in_valid = 0; in_sof = 0; in_eof = 0; in_err = 0;
    local_mac = LMAC; promisc = 0; accept_mcast = 0;
    cfg_we = 0; cfg_idx = '0; cfg_ethertype = '0; cfg_en = 0; stat_clr = 0;
    reset_n = 1'b1;
    mon_clear();
    #2;
    test_reset();
    test_basic();
    test_filter();
    test_priority();
    test_runt();
    test_abort();
    test_err();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eth_rx_dispatch.md
Name: eth_rx_dispatch

Overview:
- Controller that sits directly behind the MII receiver, on the same rx_clk domain.
- Takes the receiver's byte stream and parses the 14-byte Ethernet header.
- Filters on destination MAC and steers each accepted payload to one of N consumer channels, chosen from a runtime-configured ethertype table.
- Keeps saturating statistics for accepted and dropped frames.

Parameters:
- N_CHAN, 4, number of ethertype table entries / output channels (1..16).
- CNT_W, 16, width of each statistics counter.

Ports:
- rx_clk  in  1  receive clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  8  frame byte; first byte is dst MAC MSB, directly after the SFD.
- in_valid  in  1  in_data valid this cycle; no backpressure.
- in_sof  in  1  with in_valid: first byte of a frame.
- in_eof  in  1  with in_valid: last byte of a frame.
- in_err  in  1  with in_eof: frame carried an error (rx_er/FCS).
- local_mac  in  48  station address, byte0 = [47:40].
- promisc  in  1  accept any dst MAC.
- accept_mcast  in  1  accept dst with group bit (dst[40]) set.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  $clog2(N_CHAN) (min 1)  table entry index.
- cfg_ethertype  in  16  ethertype for the entry.
- cfg_en  in  1  entry enable.
- stat_clr  in  1  clear all counters.
- out_data  out  8  payload byte.
- out_valid  out  1  out_data valid.
- out_sof  out  1  first payload byte.
- out_eof  out  1  last payload byte.
- out_err  out  1  with out_eof: frame errored.
- out_abort  out  1  one-cycle strobe: the forwarded frame was cut short.
- out_chan  out  $clog2(N_CHAN) (min 1)  destination channel; stable from out_sof through out_eof/out_abort.
- cnt_fwd  out  CNT_W  frames forwarded.
- cnt_drop_mac  out  CNT_W  frames dropped by MAC filter.
- cnt_drop_type  out  CNT_W  frames dropped for no ethertype match.
- cnt_runt  out  CNT_W  frames ending before byte 14.

Behaviour:
- Reset (async, reset_n=0):
  - All outputs and counters = 0; state = IDLE.
  - All table entries disabled, ethertype = 0.
- Table write: registered. A write on cycle t is visible to decisions from cycle t+1. The decision is latched per frame; later writes do not affect a frame already being forwarded.
- FSM:
  - IDLE: in_valid&in_sof -> HDR, hdr_cnt=1, byte stored as dst[47:40].
  - HDR: bytes 0-5 = dst MAC, 6-11 = src MAC (discarded), 12-13 = ethertype big-endian (byte12 = MSB).
    - At byte 13, MAC accept = promisc | dst==local_mac | dst==48'hFFFF_FFFF_FFFF | (accept_mcast & dst[40]).
    - MAC reject -> DROP, cnt_drop_mac++.
    - Otherwise the lowest-index enabled entry whose ethertype matches gives out_chan -> FWD.
    - No match -> DROP, cnt_drop_type++.
    - in_eof before byte 13 -> IDLE, cnt_runt++.
    - If byte 13 is itself in_eof, it is a runt: cnt_runt++ only.
  - FWD: each input byte produces one output byte exactly 1 cycle later (registered).
    - First payload byte carries out_sof=1.
    - The in_eof byte produces out_eof=1 with out_err=in_err, then the FSM returns to IDLE and cnt_fwd++ (errored frames included).
    - A header-only frame (eof on byte 13) never enters FWD.
  - DROP: bytes ignored until in_eof -> IDLE.
- Gaps: in_valid=0 cycles inside a frame are allowed; outputs stay idle and state holds.
- in_sof while in HDR/FWD/DROP (missing eof):
  - Current frame is abandoned.
  - If in FWD: out_abort=1 for one cycle (out_valid=0 that cycle); cnt_fwd is not incremented.
  - If in HDR: cnt_runt++.
  - The new byte starts a fresh header (hdr_cnt=1).
- in_sof&in_eof on the same byte: runt, cnt_runt++, stay IDLE.
- in_valid with neither in_sof nor an active frame (IDLE): ignored.
- Counters: saturate at all-ones. stat_clr wins over a same-cycle increment, and counters read 0 the next cycle.
- out_valid/out_sof/out_eof/out_err/out_abort are single-cycle qualified pulses; out_data holds its last value when out_valid=0.

Test Plan:
- Table[1]=0x0800 en; local_mac=02:00:00:00:00:01. Send 64-byte frame to that MAC, type 0x0800 -> 50 out_valid bytes, out_chan=1, out_sof on payload byte 0, out_eof on last byte, cnt_fwd=1.
- Broadcast dst, type 0x86DD, no entry -> no out_valid, cnt_drop_type=1. Same frame to 02:00:00:00:00:02 with promisc=0 -> cnt_drop_mac=1. Set promisc=1 -> frame forwarded.
- Entries 0 and 2 both 0x0806 enabled -> out_chan=0. Disable entry 0 mid-frame after byte 13 -> current frame stays on ch0; next frame goes to ch2.
- 10-byte frame -> cnt_runt=1, no output. Forwarded frame, then in_sof after 20 bytes without eof -> out_abort pulse, cnt_fwd unchanged, new frame parsed normally.
- Forwarded frame ending with in_err=1 -> out_eof with out_err=1, cnt_fwd incremented.
- Preset cnt_fwd to 0xFFFF via 65535 frames (or force) -> stays 0xFFFF. stat_clr concurrent with an increment -> 0. Assert reset_n low mid-FWD -> outputs 0 immediately, no out_eof.
